// File: rtl/cpa_seq_ctrl.sv
// Sequential carry-propagate adder controller.
// One WIDTH-bit ripple adder is shared across NSLICE slices, least-significant
// slice first. Operands are latched on accept and the result is held until the
// consumer takes it.
// Optional feature: define CPA_SEQ_OVF_EN to add the signed overflow output ovf.

// WIDTH-bit ripple-carry adder; the controller instantiates it exactly once.
module cpa_seq_ripple #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o
);

    // Bit-serial carry chain across the slice
    always_comb begin
        logic c;
        c   = c_i;
        s_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c;
            c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        co_o = c;
    end

endmodule

// state | meaning
// IDLE  | waiting for a request; in_ready high, previous sum held
// RUN   | adding one slice per cycle, cnt selects the slice
// DONE  | result valid; held until out_ready
module cpa_seq_ctrl #(
    parameter int WIDTH  = 8,
    parameter int NSLICE = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*NSLICE-1:0]  a,
    input  logic [WIDTH*NSLICE-1:0]  b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*NSLICE-1:0]  sum,
`ifdef CPA_SEQ_OVF_EN
    output logic                     ovf,
`endif
    output logic                     cout
);

    localparam int TOT   = WIDTH * NSLICE;
    localparam int CNT_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [TOT-1:0]     a_q, a_d;
    logic [TOT-1:0]     b_q, b_d;
    logic [TOT-1:0]     sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef CPA_SEQ_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [WIDTH-1:0]   slice_a;
    logic [WIDTH-1:0]   slice_b;
    logic [WIDTH-1:0]   slice_s;
    logic               slice_co;

    // Select the active slice of the latched operands for the shared adder
    always_comb begin
        slice_a = a_q[int'(cnt_q) * WIDTH +: WIDTH];
        slice_b = b_q[int'(cnt_q) * WIDTH +: WIDTH];
    end

    cpa_seq_ripple #(
        .WIDTH (WIDTH)
    ) u_cpa (
        .a_i  (slice_a),
        .b_i  (slice_b),
        .c_i  (carry_q),
        .s_o  (slice_s),
        .co_o (slice_co)
    );

    // Next-state, datapath updates and handshake decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef CPA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(cnt_q) * WIDTH +: WIDTH] = slice_s;
                carry_d = slice_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    // Counter is reloaded on the next accept; park it at zero.
                    cnt_d   = '0;
                    cout_d  = slice_co;
                    state_d = DONE;
`ifdef CPA_SEQ_OVF_EN
                    // The top slice result carries the final sign bit.
                    ovf_d   = (a_q[TOT-1] == b_q[TOT-1]) &&
                              (slice_s[WIDTH-1] != a_q[TOT-1]);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CPA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef CPA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef CPA_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cpa_seq_ctrl.sv
// Scoreboard bench for cpa_seq_ctrl (WIDTH=8, NSLICE=4).
// Optional CPA_SEQ_OVF_EN also checks the ovf output.
module tb_cpa_seq_ctrl;

    localparam int WIDTH  = 8;
    localparam int NSLICE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
`ifdef CPA_SEQ_OVF_EN
    logic        ovf;
`endif

    cpa_seq_ctrl #(
        .WIDTH  (WIDTH),
        .NSLICE (NSLICE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef CPA_SEQ_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares on the rising of out_valid, checks hold while valid,
    // retires the entry when the handshake completes.
    logic        ov_prev = 1'b0;
    logic [31:0] held_s;
    logic        held_c;
    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid) begin
                chk("in_ready_in_done", in_ready, 0);
                if (!ov_prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got sum %0h, expected no out_valid", sum);
                    end else begin
                        chk("sum", sum, sb[0].s);
                        chk("cout", cout, sb[0].c);
                        chk("latency", cyc - sb[0].acc, NSLICE);
`ifdef CPA_SEQ_OVF_EN
                        chk("ovf", ovf, sb[0].o);
`endif
                    end
                    held_s = sum;
                    held_c = cout;
                end else begin
                    chk("hold_sum", sum, held_s);
                    chk("hold_cout", cout, held_c);
                end
                if (out_ready && sb.size() > 0) void'(sb.pop_front());
            end
            ov_prev = out_valid;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL wait_idle: in_ready got 0 expected 1");
                return;
            end
        end
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                        input logic [31:0] es, input logic ec, input logic eo, input bit push);
        wait_idle();
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~av; b = ~bv; cin = ~cv;
        if (push) sb.push_back('{es, ec, eo, cyc});
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0) begin
            @(posedge clk); #1;
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d results outstanding expected 0", sb.size());
                sb.delete();
                return;
            end
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef CPA_SEQ_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        @(posedge clk); #1;

        // Directed vectors: a, b, cin -> sum, cout, ovf
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1); drain();
        send(32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1); drain();
        send(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1); drain();
        send(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1); drain();
        send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1); drain();
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1); drain();
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1); drain();

        // Back-pressure: hold result in DONE for 3 cycles
        out_ready = 1'b0;
        send(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1);
        wait_valid("bp_out_valid");
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", in_ready, 1);
        chk("bp_out_valid_after", out_valid, 0);
        @(posedge clk); #1;
        chk("idle_sum_retained", sum, 32'h00010000);

        // Reset during the second RUN cycle aborts the operation
        send(32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h0, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_sum", sum, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        repeat (8) @(posedge clk);
        #1;
        send(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1); drain();

        // in_valid held high with changing operands during RUN
        out_ready = 1'b0;
        send(32'h00010001, 32'h00020002, 1'b0, 32'h00030003, 1'b0, 1'b0, 1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                in_valid = 1'b1;
                a = $urandom;
                b = $urandom;
                cin = 1'b1;
                @(posedge clk); #1;
                n++;
            end
        end
        in_valid = 1'b0;
        chk("busy_out_valid", out_valid, 1);
        out_ready = 1'b1;
        drain();
        repeat (8) @(posedge clk);
        #1;
        chk("busy_final_idle", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpa_seq_ctrl.md
CPA_SEQ_CTRL -- requirements
Module: cpa_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: bit width of one CPA slice.
REQ-002 The block SHALL have parameter NSLICE, default 4: number of slices per operand, legal range NSLICE >= 1.
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input rst_n, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have input in_valid, 1 bit: the operand request is valid.
REQ-006 The block SHALL have output in_ready, 1 bit: the block can accept a request.
REQ-007 The block SHALL have inputs a and b, each WIDTH*NSLICE bits: the addends.
REQ-008 The block SHALL have input cin, 1 bit: the carry-in of the whole add.
REQ-009 The block SHALL have output out_valid, 1 bit: the result is valid.
REQ-010 The block SHALL have input out_ready, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have output sum, WIDTH*NSLICE bits: the registered result.
REQ-012 The block SHALL have output cout, 1 bit: the registered carry-out of the top slice.

Function
REQ-013 The block SHALL time-share exactly one WIDTH-bit ripple CPA instance across all NSLICE slices, least-significant slice first.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
- in_ready = 1 only in IDLE.
- out_valid = 1 only in DONE.
REQ-015 In IDLE, when in_valid && in_ready, the block SHALL:
- latch a, b and cin;
- clear slice counter cnt to 0;
- set the carry register to cin;
- go to RUN.
REQ-016 In RUN, each cycle the block SHALL:
- add slice cnt of a and b with the carry register;
- write the slice result into sum[cnt*WIDTH +: WIDTH];
- load the CPA carry-out into the carry register;
- increment cnt.
REQ-017 When cnt == NSLICE-1 in RUN, the block SHALL go to DONE at the same edge and set cout to that slice's carry-out.
REQ-018 out_valid SHALL rise exactly NSLICE clock edges after the accepting edge (NSLICE=1 gives one RUN cycle).
REQ-019 In DONE with out_ready = 0, the block SHALL hold sum, cout and out_valid stable for any number of cycles.
REQ-020 In DONE with out_ready = 1, the block SHALL go to IDLE at the next edge.
- in_ready is low in DONE, so back-to-back operations have one IDLE bubble.
- in_valid asserted in DONE is not accepted until IDLE.
REQ-021 in_valid, a, b and cin SHALL be ignored in RUN and DONE; latched operands SHALL NOT change mid-operation.
REQ-022 The result SHALL equal (a + b + cin) mod 2^(WIDTH*NSLICE), with cout the bit at position WIDTH*NSLICE.
REQ-023 sum SHALL retain its last completed value while in IDLE.

Reset
REQ-024 When rst_n = 0 at a rising clk edge, the block SHALL:
- set state to IDLE;
- set cnt, the carry register, sum and cout to 0.
REQ-025 Reset values SHALL be out_valid = 0, in_ready = 1 after the reset edge, and ovf = 0 when present.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid SHALL be produced for it.

Configuration
REQ-027 With macro CPA_SEQ_OVF_EN defined, the block SHALL add output ovf, 1 bit, the signed two's-complement overflow flag.
- Registered when entering DONE.
- ovf = (a_msb == b_msb) && (sum_msb != a_msb); cin is included in the sum.
- Valid with out_valid and held with sum.
REQ-028 Without CPA_SEQ_OVF_EN, the block SHALL NOT have port ovf or its logic; all other behaviour is identical.

Verification (WIDTH=8, NSLICE=4)
REQ-029 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, out_valid exactly 4 edges after the accept.
REQ-030 a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A, cout=0; carry propagates correctly across slice boundaries.
REQ-031 Hold out_ready=0 for 3 cycles in DONE -> sum, cout and out_valid are stable, and in_ready=0. Raise out_ready -> IDLE, with in_ready=1 on the next cycle.
REQ-032 Assert rst_n=0 for one edge during the 2nd RUN cycle -> state IDLE, sum=0, and out_valid never rises. The next request (0x1+0x1, cin=0) gives sum=0x00000002.
REQ-033 With CPA_SEQ_OVF_EN defined: a=0x7FFFFFFF, b=0x00000001 -> ovf=1, sum=0x80000000. a=0xFFFFFFFF, b=0x00000001 -> ovf=0.
REQ-034 Drive in_valid high continuously with new operands during RUN -> only the first request completes, and its latched operands determine sum.
